// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-to-hazard-controller signal bundle
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             fwd_en;
   logic [3:0]       id_src1;
   logic [3:0]       id_src2;
   logic             id_use_src1;
   logic             id_two_src;
   logic [3:0]       exe_dest;
   logic             exe_wb_en;
   logic             exe_mem_r_en;
   logic [3:0]       mem_dest;
   logic             mem_wb_en;
   logic             branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             freeze_if;
   logic             freeze_id;
   logic             freeze_exe;
   logic             freeze_mem;
   logic             flush_if;
   logic             flush_id;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   modport master (
      output fwd_en, id_src1, id_src2, id_use_src1, id_two_src, exe_dest, exe_wb_en,
             exe_mem_r_en, mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
      input  freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if, flush_id, halted,
             stall_cnt, flush_cnt
   );
   modport slave (
      input  fwd_en, id_src1, id_src2, id_use_src1, id_two_src, exe_dest, exe_wb_en,
             exe_mem_r_en, mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
      output freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if, flush_id, halted,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline freeze/flush sequencer with memory timeout halt and perf counters
module pipe_hazard_ctrl #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int WW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_e;
   state_e           state_q, state_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
   logic             m1, m2, n1, n2, hazard, mem_stall, fr_all, br, bub, fr_if;
   // RAW detection and priority resolution; outputs are forced low while reset is held
   always_comb begin
      m1        = bus.id_use_src1 & (bus.id_src1 == bus.exe_dest);
      m2        = bus.id_two_src & (bus.id_src2 == bus.exe_dest);
      n1        = bus.id_use_src1 & (bus.id_src1 == bus.mem_dest);
      n2        = bus.id_two_src & (bus.id_src2 == bus.mem_dest);
      hazard    = bus.fwd_en ? (bus.exe_wb_en & bus.exe_mem_r_en & (m1 | m2))
                             : ((bus.exe_wb_en & (m1 | m2)) | (bus.mem_wb_en & (n1 | n2)));
      mem_stall = (bus.mem_req & ~bus.mem_ready) | (state_q == HALT);
      fr_all    = rst_n & mem_stall;
      br        = rst_n & ~mem_stall & bus.branch_taken;
      bub       = rst_n & ~mem_stall & ~bus.branch_taken & hazard;
      fr_if     = fr_all | bub;
   end
   // memory handshake FSM: wait counter restarts on every entry to MEM_WAIT
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         RUN: begin
            if (bus.mem_req && !bus.mem_ready) begin
               state_d = MEM_WAIT;
               wait_d  = '0;
            end
         end
         MEM_WAIT: begin
            if (bus.mem_ready) state_d = RUN;
            else if (wait_q == WW'(TIMEOUT - 1)) state_d = HALT;
            else wait_d = wait_q + 1'b1;
         end
         default: state_d = HALT;
      endcase
   end
   // saturating counters; flush_cnt holds in HALT naturally since flush_if is then low
   always_comb begin
      stall_d = (fr_if && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
      flush_d = (br && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
   end
   // state and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         wait_q  <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end
   assign bus.freeze_if  = fr_if;
   assign bus.freeze_id  = fr_all;
   assign bus.freeze_exe = fr_all;
   assign bus.freeze_mem = fr_all;
   assign bus.flush_if   = br;
   assign bus.flush_id   = br | bub;
   assign bus.halted     = state_q == HALT;
   assign bus.stall_cnt  = stall_q;
   assign bus.flush_cnt  = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   pipe_hazard_ctrl_if #(.CNT_W(4)) bus ();
   pipe_hazard_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   typedef struct {
      string      nm;
      logic       rb;
      logic       fwd, use1;
      logic [3:0] src1;
      logic       two;
      logic [3:0] src2, edst;
      logic       ewb, eld;
      logic [3:0] mdst;
      logic       mwb, br, req, rdy;
      logic [6:0] exp;
   } vec_t;
   typedef struct {
      string      nm;
      logic [6:0] o;
      logic [3:0] sc, fc;
   } exp_t;
   vec_t       tbl[$];
   exp_t       sb[$];
   int         pass_cnt = 0;
   int         total = 0;
   logic [3:0] m_stall = '0;
   logic [3:0] m_flush = '0;
   logic [6:0] outs;
   assign outs = {bus.freeze_if, bus.freeze_id, bus.freeze_exe, bus.freeze_mem,
                  bus.flush_if, bus.flush_id, bus.halted};
   function automatic vec_t mk(string nm, logic rb, logic fwd, logic use1, logic [3:0] src1,
                               logic two, logic [3:0] src2, logic [3:0] edst, logic ewb,
                               logic eld, logic [3:0] mdst, logic mwb, logic br, logic req,
                               logic rdy, logic [6:0] exp);
      vec_t v;
      v.nm = nm; v.rb = rb; v.fwd = fwd; v.use1 = use1; v.src1 = src1; v.two = two;
      v.src2 = src2; v.edst = edst; v.ewb = ewb; v.eld = eld; v.mdst = mdst; v.mwb = mwb;
      v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
      return v;
   endfunction
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   task automatic drive(vec_t v);
      bus.fwd_en = v.fwd; bus.id_use_src1 = v.use1; bus.id_src1 = v.src1;
      bus.id_two_src = v.two; bus.id_src2 = v.src2; bus.exe_dest = v.edst;
      bus.exe_wb_en = v.ewb; bus.exe_mem_r_en = v.eld; bus.mem_dest = v.mdst;
      bus.mem_wb_en = v.mwb; bus.branch_taken = v.br; bus.mem_req = v.req;
      bus.mem_ready = v.rdy;
   endtask
   task automatic do_reset();
      drive(mk("rst", 0, 1, 1, 3, 0, 0, 3, 1, 1, 0, 0, 1, 1, 0, 7'b0));
      rst_n = 1'b0;
      #2;
      chk("rst.out", 32'(outs), 32'd0);
      chk("rst.stall", 32'(bus.stall_cnt), 32'd0);
      chk("rst.flush", 32'(bus.flush_cnt), 32'd0);
      drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      m_stall = '0;
      m_flush = '0;
   endtask
   task automatic step(vec_t v);
      exp_t e;
      exp_t g;
      drive(v);
      e.nm = v.nm; e.o = v.exp; e.sc = m_stall; e.fc = m_flush;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
         total++;
         $display("FAIL %s: scoreboard empty", v.nm);
      end else begin
         g = sb.pop_front();
         chk({g.nm, ".out"}, 32'(outs), 32'(g.o));
         chk({g.nm, ".stall"}, 32'(bus.stall_cnt), 32'(g.sc));
         chk({g.nm, ".flush"}, 32'(bus.flush_cnt), 32'(g.fc));
      end
      @(posedge clk);
      if (v.exp[6] && !(&m_stall)) m_stall = m_stall + 4'd1;
      if (v.exp[2] && !(&m_flush)) m_flush = m_flush + 4'd1;
      #1;
   endtask
   initial begin
      //             nm          rb fwd u1 s1 two s2 ed ewb eld md mwb br req rdy exp
      tbl.push_back(mk("idle",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
      tbl.push_back(mk("lu",      0, 1, 1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 7'b1000010));
      tbl.push_back(mk("lu_nold", 0, 1, 1, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 7'b0000000));
      tbl.push_back(mk("lu_src2", 0, 1, 0, 0, 1, 3, 3, 1, 1, 0, 0, 0, 0, 0, 7'b1000010));
      tbl.push_back(mk("lu_no2",  0, 1, 0, 0, 0, 3, 3, 1, 1, 0, 0, 0, 0, 0, 7'b0000000));
      tbl.push_back(mk("lu_nowb", 0, 1, 1, 3, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 7'b0000000));
      tbl.push_back(mk("nf_mem2", 0, 0, 0, 0, 1, 5, 0, 0, 0, 5, 1, 0, 0, 0, 7'b1000010));
      tbl.push_back(mk("nf_no2",  0, 0, 0, 0, 0, 5, 0, 0, 0, 5, 1, 0, 0, 0, 7'b0000000));
      tbl.push_back(mk("nf_exe",  0, 0, 1, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 7'b1000010));
      tbl.push_back(mk("fw_exe",  0, 1, 1, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 7'b0000000));
      tbl.push_back(mk("nf_mem1", 0, 0, 1, 5, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 7'b1000010));
      tbl.push_back(mk("br_lu",   0, 1, 1, 3, 0, 0, 3, 1, 1, 0, 0, 1, 0, 0, 7'b0000110));
      tbl.push_back(mk("br",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000110));
      tbl.push_back(mk("mw1",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1111000));
      tbl.push_back(mk("mw2_br",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b1111000));
      tbl.push_back(mk("mw3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1111000));
      tbl.push_back(mk("mw_rdy",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000000));
      tbl.push_back(mk("mw_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk("to_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1111000));
      tbl.push_back(mk("halt_rdy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1111001));
      tbl.push_back(mk("halt_br",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1111001));
      tbl.push_back(mk("halt_lu",  0, 1, 1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 7'b1111001));
      tbl.push_back(mk("post_halt", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
      tbl.push_back(mk("mw_a",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1111000));
      tbl.push_back(mk("mw_b",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1111000));
      tbl.push_back(mk("mw_c",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1111000));
      tbl.push_back(mk("mw_d",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1111000));
      tbl.push_back(mk("mw_rdy2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000000));
      tbl.push_back(mk("mw_idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
      for (int k = 0; k < 20; k++)
         tbl.push_back(mk("sat", k == 0, 1, 1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 7'b1000010));
      foreach (tbl[i]) begin
         if (tbl[i].rb) do_reset();
         step(tbl[i]);
      end
      chk("sat.stall_final", 32'(bus.stall_cnt), 32'd15);
      chk("sat.flush_final", 32'(bus.flush_cnt), 32'd0);
      chk("sb.empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core. Drives the freeze/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Three stall/flush sources:
  - RAW data hazards (load-use only when forwarding is on; any producer when off).
  - Taken branches resolved in EX.
  - Multi-cycle data-memory accesses (SRAM handshake), with timeout-to-halt.
- Also keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of the performance counters.
- TIMEOUT, 64, maximum MEM_WAIT cycles before halt. Must be ≥ 1.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- fwd_en  in  1  forwarding unit enabled
- id_src1  in  4  Rn of instruction in ID
- id_src2  in  4  Rm/Rd-store source of instruction in ID
- id_use_src1  in  1  ID instruction reads Rn
- id_two_src  in  1  ID instruction reads id_src2
- exe_dest  in  4  destination register in EX
- exe_wb_en  in  1  EX instruction writes back
- exe_mem_r_en  in  1  EX instruction is a load
- mem_dest  in  4  destination register in MEM
- mem_wb_en  in  1  MEM instruction writes back
- branch_taken  in  1  EX branch taken this cycle
- mem_req  in  1  MEM stage has a load/store in flight
- mem_ready  in  1  SRAM completes access this cycle
- freeze_if  out  1  hold PC and IF/ID register
- freeze_id  out  1  hold ID/EX register
- freeze_exe  out  1  hold EX/MEM register
- freeze_mem  out  1  hold MEM/WB register
- flush_if  out  1  clear IF/ID register
- flush_id  out  1  load bubble into ID/EX register
- halted  out  1  sticky memory-timeout halt
- stall_cnt  out  CNT_W  cycles with freeze_if asserted
- flush_cnt  out  CNT_W  cycles with branch flush

Behaviour:
- Reset (rst=0, async):
  - State=RUN; wait_cnt=0; stall_cnt=0; flush_cnt=0; halted=0.
  - All freeze/flush outputs forced 0 while rst=0.
- State machine, 2-bit: RUN, MEM_WAIT, HALT.
  - RUN→MEM_WAIT: mem_req=1 & mem_ready=0.
  - MEM_WAIT→RUN: mem_ready=1. Data is captured that cycle and freeze drops in the same cycle.
  - MEM_WAIT→HALT: wait_cnt==TIMEOUT-1 & mem_ready=0.
  - HALT: terminal until reset. halted=1.
  - wait_cnt clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
- mem_stall (combinational) = (mem_req & ~mem_ready) | state==HALT.
- hazard (combinational):
  - m1 = id_use_src1 & id_src1==exe_dest; m2 = id_two_src & id_src2==exe_dest.
  - fwd_en=1: hazard = exe_wb_en & exe_mem_r_en & (m1|m2).
  - fwd_en=0: hazard = (exe_wb_en & (m1|m2)) | (mem_wb_en & ((id_use_src1 & id_src1==mem_dest) | (id_two_src & id_src2==mem_dest))).
- Output priority, highest first, all combinational from state and current inputs (zero-latency, same cycle):
  1. mem_stall: all four freezes=1; flush_if=flush_id=0.
  2. branch_taken: flush_if=1, flush_id=1; freezes=0. Hazard ignored.
  3. hazard: freeze_if=1, flush_id=1 (bubble); other freezes=0.
  4. Otherwise all 0.
- Counters, registered, saturate at all-ones (no wrap):
  - stall_cnt +1 on each clock edge with freeze_if=1.
  - flush_cnt +1 on each clock edge with flush_if=1.
  - Counters hold in HALT except stall_cnt, which keeps counting until saturation.
- Reset asserted mid-MEM_WAIT or in HALT: immediate return to RUN, outputs 0.

Test Plan:
- Load-use: fwd_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_src1=3, id_use_src1=1 for 1 cycle → freeze_if=1, flush_id=1, freeze_id=0; stall_cnt 0→1. Same with exe_mem_r_en=0 → all outputs 0.
- No-forward RAW: fwd_en=0, mem_wb_en=1, mem_dest=5, id_two_src=1, id_src2=5 → freeze_if=1, flush_id=1. Same with id_two_src=0 → no stall.
- Branch over hazard: branch_taken=1 with active load-use hazard → flush_if=1, flush_id=1, freeze_if=0; flush_cnt +1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 → all freezes=1 for 3 cycles, 0 on ready cycle. State RUN→MEM_WAIT→RUN; stall_cnt=3. Concurrent branch_taken gives flush_if=0 during the wait.
- Timeout: TIMEOUT=4, mem_ready held 0 → HALT after 5th stalled edge. halted=1, freezes stay 1 after mem_ready=1. Pulse rst=0 → halted=0, state RUN, counters 0.
- Saturation: CNT_W=4, hazard held 20 cycles → stall_cnt stops at 15.
